pipe_mips32: RTL and testbench

- Five-stage (IF, ID, EX, MEM, WB) in-order pipelined 32-bit RISC core for a MIPS32 subset.
- Unified word-addressed instruction/data memory, 32x32 register file, forwarding and load-use interlock.
- Top-level CPU block; benches preload Mem/Reg hierarchically and observe results through them.

---
 rtl/pipe_mips32_pkg.sv | 54 +++++
 rtl/pipe_mips32_if.sv | 12 +
 rtl/pipe_mips32_alu.sv | 22 ++
 rtl/pipe_mips32.sv | 181 ++++++++++++++++++
 tb/tb_pipe_mips32.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the pipe_mips32 core: opcodes, instruction classes
// and instruction field helpers.
package pipe_mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    typedef enum logic [2:0] {NOP, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} itype_t;

    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ir);
        return {{16{ir[15]}}, ir[15:0]};
    endfunction

    function automatic itype_t type_of(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

endpackage

// File: rtl/pipe_mips32_if.sv
// Retirement trace of the core: register writebacks and memory stores.
interface pipe_mips32_if;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    modport master (output wb_valid, wb_reg, wb_data, st_valid, st_addr, st_data);
    modport slave  (input  wb_valid, wb_reg, wb_data, st_valid, st_addr, st_data);
endinterface

// File: rtl/pipe_mips32_alu.sv
// Combinational EX-stage ALU; loads/stores use it for address generation.
module pipe_mips32_alu
    import pipe_mips32_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_SUB, OP_SUBI:               result = a - b;
            OP_AND:                        result = a & b;
            OP_OR:                         result = a | b;
            OP_SLT, OP_SLTI:               result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:                        result = a * b;
            default:                       result = '0;
        endcase
    end
endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core with unified memory, forwarding,
// load-use interlock and EX-resolved branches.
module pipe_mips32
    import pipe_mips32_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned NREGS     = 32
) (
    input  logic          clk1,
    input  logic          rst_n,
    output logic          halted,
    pipe_mips32_if.master trace
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] Reg [0:NREGS-1];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        fetch_stopped;

    logic        ifid_valid;
    logic [31:0] ifid_ir, ifid_npc;

    logic        idex_valid, idex_wen;
    itype_t      idex_type;
    logic [5:0]  idex_op;
    logic [4:0]  idex_rs, idex_rt, idex_dest;
    logic [31:0] idex_a, idex_b, idex_imm, idex_npc;

    logic        exmem_valid, exmem_wen;
    itype_t      exmem_type;
    logic [4:0]  exmem_dest;
    logic [31:0] exmem_alu, exmem_b;

    logic        memwb_valid, memwb_wen;
    itype_t      memwb_type;
    logic [4:0]  memwb_dest;
    logic [31:0] memwb_result;

    itype_t      id_type;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rs, id_uses_rt, id_wen, id_is_halt;
    logic [31:0] id_a, id_b;
    logic        wb_we, mem_we, load_stall, fetch_hold, branch_taken;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_out, branch_target, fetch_ir, mem_rdata;

    assign wb_we     = memwb_valid && memwb_wen && !HALTED;
    assign mem_we    = exmem_valid && (exmem_type == STORE) && !HALTED;
    assign fetch_ir  = Mem[PC[AW-1:0]];
    assign mem_rdata = Mem[exmem_alu[AW-1:0]];

    // Register reads are write-through so WB and ID can share a cycle.
    always_comb begin
        id_type    = type_of(op_of(ifid_ir));
        id_rs      = rs_of(ifid_ir);
        id_rt      = rt_of(ifid_ir);
        id_dest    = (id_type == RR_ALU) ? rd_of(ifid_ir) : id_rt;
        id_uses_rs = ifid_valid && (id_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH});
        id_uses_rt = ifid_valid && (id_type inside {RR_ALU, STORE});
        id_wen     = ifid_valid && (id_type inside {RR_ALU, RM_ALU, LOAD}) && (id_dest != 5'd0);
        id_is_halt = ifid_valid && (id_type == HALT);
        id_a       = (wb_we && memwb_dest == id_rs) ? memwb_result : Reg[id_rs];
        id_b       = (wb_we && memwb_dest == id_rt) ? memwb_result : Reg[id_rt];
        load_stall = idex_valid && (idex_type == LOAD) && idex_wen &&
                     ((id_uses_rs && id_rs == idex_dest) || (id_uses_rt && id_rt == idex_dest));
        fetch_hold = fetch_stopped || id_is_halt;
    end

    // A load in EX/MEM has no data yet; the interlock guarantees nobody needs it.
    always_comb begin
        fwd_a = idex_a;
        if (exmem_valid && exmem_wen && exmem_type != LOAD && exmem_dest == idex_rs)
            fwd_a = exmem_alu;
        else if (memwb_valid && memwb_wen && memwb_dest == idex_rs)
            fwd_a = memwb_result;
        fwd_b = idex_b;
        if (exmem_valid && exmem_wen && exmem_type != LOAD && exmem_dest == idex_rt)
            fwd_b = exmem_alu;
        else if (memwb_valid && memwb_wen && memwb_dest == idex_rt)
            fwd_b = memwb_result;
        alu_b         = (idex_type == RR_ALU) ? fwd_b : idex_imm;
        branch_taken  = idex_valid && (idex_type == BRANCH) &&
                        ((idex_op == OP_BEQZ) == (fwd_a == '0));
        branch_target = idex_npc + idex_imm;
    end

    pipe_mips32_alu u_alu (.op(idex_op), .a(fwd_a), .b(alu_b), .result(alu_out));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            PC            <= '0;
            HALTED        <= 1'b0;
            fetch_stopped <= 1'b0;
            ifid_valid    <= 1'b0;
            ifid_ir       <= '0;
            ifid_npc      <= '0;
            idex_valid    <= 1'b0;
            idex_wen      <= 1'b0;
            idex_type     <= NOP;
            idex_op       <= '0;
            idex_rs       <= '0;
            idex_rt       <= '0;
            idex_dest     <= '0;
            idex_a        <= '0;
            idex_b        <= '0;
            idex_imm      <= '0;
            idex_npc      <= '0;
            exmem_valid   <= 1'b0;
            exmem_wen     <= 1'b0;
            exmem_type    <= NOP;
            exmem_dest    <= '0;
            exmem_alu     <= '0;
            exmem_b       <= '0;
            memwb_valid   <= 1'b0;
            memwb_wen     <= 1'b0;
            memwb_type    <= NOP;
            memwb_dest    <= '0;
            memwb_result  <= '0;
        end else begin
            if (branch_taken)
                PC <= branch_target;
            else if (!load_stall && !fetch_hold)
                PC <= PC + 32'd1;
            if (id_is_halt && !branch_taken)
                fetch_stopped <= 1'b1;

            if (branch_taken) begin
                ifid_valid <= 1'b0;
            end else if (!load_stall) begin
                ifid_valid <= !fetch_hold;
                ifid_ir    <= fetch_ir;
                ifid_npc   <= PC + 32'd1;
            end

            idex_valid <= ifid_valid && !branch_taken && !load_stall;
            idex_wen   <= id_wen;
            idex_type  <= id_type;
            idex_op    <= op_of(ifid_ir);
            idex_rs    <= id_rs;
            idex_rt    <= id_rt;
            idex_dest  <= id_dest;
            idex_a     <= id_a;
            idex_b     <= id_b;
            idex_imm   <= imm_of(ifid_ir);
            idex_npc   <= ifid_npc;

            exmem_valid <= idex_valid;
            exmem_wen   <= idex_wen;
            exmem_type  <= idex_type;
            exmem_dest  <= idex_dest;
            exmem_alu   <= alu_out;
            exmem_b     <= fwd_b;

            memwb_valid  <= exmem_valid;
            memwb_wen    <= exmem_wen;
            memwb_type   <= exmem_type;
            memwb_dest   <= exmem_dest;
            memwb_result <= (exmem_type == LOAD) ? mem_rdata : exmem_alu;

            if (memwb_valid && memwb_type == HALT)
                HALTED <= 1'b1;
        end
    end

    // Architectural storage is deliberately not reset so preloads survive reset.
    always_ff @(posedge clk1) begin
        if (mem_we)
            Mem[exmem_alu[AW-1:0]] <= exmem_b;
        if (wb_we)
            Reg[memwb_dest] <= memwb_result;
    end

    assign halted         = HALTED;
    assign trace.wb_valid = wb_we;
    assign trace.wb_reg   = memwb_dest;
    assign trace.wb_data  = memwb_result;
    assign trace.st_valid = mem_we;
    assign trace.st_addr  = exmem_alu;
    assign trace.st_data  = exmem_b;
endmodule

// File: tb/tb_pipe_mips32.sv
// Scoreboard bench for pipe_mips32: directed programs, expected writebacks and
// stores queued up front and matched against the retirement trace.
module tb_pipe_mips32;
    import pipe_mips32_pkg::*;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    pipe_mips32_if trace();

    pipe_mips32 #(.MEM_WORDS(1024), .NREGS(32)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .halted(halted),
        .trace (trace)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t   exp_reg[$];
    ev_t   exp_st[$];
    ev_t   mon_wb, mon_st;
    int    checks = 0;
    int    failures = 0;
    string tname = "init";

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s.%s: got %0d (0x%08h), expected %0d (0x%08h)",
                     tname, name, actual, actual, expected, expected);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [31:0] w;
        w = {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
        return w;
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {op, rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] hlt();
        logic [31:0] w;
        w = {OP_HLT, 26'd0};
        return w;
    endfunction

    task automatic exp_wb(input int r, input int d);
        ev_t e;
        e.addr = r;
        e.data = d;
        exp_reg.push_back(e);
    endtask

    task automatic exp_store(input int a, input int d);
        ev_t e;
        e.addr = a;
        e.data = d;
        exp_st.push_back(e);
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.Mem[addr] = w;
    endtask

    // Scoreboard monitor: every trace event must match the head of its queue.
    always @(negedge clk1) begin
        if (trace.wb_valid) begin
            if (exp_reg.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.wb_unexpected: got R%0d <= %0d, expected no write",
                         tname, trace.wb_reg, trace.wb_data);
            end else begin
                mon_wb = exp_reg.pop_front();
                check("wb_reg", {27'd0, trace.wb_reg}, mon_wb.addr);
                check("wb_data", trace.wb_data, mon_wb.data);
            end
        end
        if (trace.st_valid) begin
            if (exp_st.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.st_unexpected: got Mem[%0d] <= %0d, expected no store",
                         tname, trace.st_addr, trace.st_data);
            end else begin
                mon_st = exp_st.pop_front();
                check("st_addr", trace.st_addr, mon_st.addr);
                check("st_data", trace.st_data, mon_st.data);
            end
        end
    end

    task automatic prep(input string name);
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        tname = name;
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.Reg[i] = i;
    endtask

    task automatic run_prog(input int budget, input int exp_cycles);
        int cyc = 0;
        check("reset_pc", dut.PC, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        while (cyc < budget && !halted) begin
            @(posedge clk1);
            cyc++;
            #1;
        end
        check("halted_within_budget", {31'd0, halted}, 32'd1);
        check("cycles_to_halt", cyc, exp_cycles);
        repeat (6) @(posedge clk1);
        #1;
        check("halted_sticky", {31'd0, halted}, 32'd1);
        check("wb_queue_drained", exp_reg.size(), 32'd0);
        check("st_queue_drained", exp_st.size(), 32'd0);
        exp_reg.delete();
        exp_st.delete();
    endtask

    task automatic load_fwd_prog();
        put(0, ri(OP_ADDI, 0, 1, 10));
        put(1, rr(OP_ADD, 1, 1, 2));
        put(2, rr(OP_SUB, 2, 1, 3));
        put(3, hlt());
        put(4, ri(OP_ADDI, 0, 5, 9));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Memory swap through loads and stores.
        prep("swap");
        put(0, ri(OP_ADDI, 0, 1, 120));
        put(1, ri(OP_ADDI, 0, 3, 240));
        put(2, rr(OP_OR, 7, 7, 15));
        put(3, rr(OP_OR, 7, 7, 15));
        put(4, ri(OP_LW, 1, 2, 0));
        put(5, ri(OP_LW, 3, 4, 0));
        put(6, ri(OP_SW, 3, 2, 0));
        put(7, ri(OP_SW, 1, 4, 0));
        put(8, hlt());
        dut.Mem[120] = 32'd40;
        dut.Mem[240] = 32'd80;
        exp_wb(1, 120); exp_wb(3, 240); exp_wb(15, 7); exp_wb(15, 7);
        exp_wb(2, 40);  exp_wb(4, 80);
        exp_store(240, 40); exp_store(120, 80);
        run_prog(20, 13);
        check("mem120", dut.Mem[120], 32'd80);
        check("mem240", dut.Mem[240], 32'd40);

        // Back-to-back forwarding; the ADDI after HLT must never retire.
        prep("forward");
        load_fwd_prog();
        dut.Reg[5] = 32'd5;
        exp_wb(1, 10); exp_wb(2, 20); exp_wb(3, 10);
        run_prog(30, 8);
        check("r1", dut.Reg[1], 32'd10);
        check("r2", dut.Reg[2], 32'd20);
        check("r3", dut.Reg[3], 32'd10);
        check("r5_untouched", dut.Reg[5], 32'd5);
        check("pc_frozen", dut.PC, 32'd4);

        // Load-use: one bubble makes this one cycle longer than the forwarding run.
        prep("load_use");
        put(0, ri(OP_ADDI, 0, 1, 200));
        put(1, ri(OP_LW, 1, 2, 0));
        put(2, ri(OP_ADDI, 2, 3, 1));
        put(3, hlt());
        dut.Mem[200] = 32'd7;
        exp_wb(1, 200); exp_wb(2, 7); exp_wb(3, 8);
        run_prog(30, 9);
        check("r3", dut.Reg[3], 32'd8);

        // BNEQZ loop, two taken branches each costing two cycles.
        prep("loop");
        put(0, ri(OP_ADDI, 0, 1, 3));
        put(1, ri(OP_ADDI, 0, 2, 0));
        put(2, ri(OP_ADDI, 2, 2, 5));
        put(3, ri(OP_SUBI, 1, 1, 1));
        put(4, ri(OP_BNEQZ, 1, 0, -3));
        put(5, hlt());
        put(6, ri(OP_ADDI, 0, 5, 9));
        exp_wb(1, 3);  exp_wb(2, 0);
        exp_wb(2, 5);  exp_wb(1, 2);
        exp_wb(2, 10); exp_wb(1, 1);
        exp_wb(2, 15); exp_wb(1, 0);
        run_prog(60, 20);
        check("r1", dut.Reg[1], 32'd0);
        check("r2", dut.Reg[2], 32'd15);
        check("r5_untouched", dut.Reg[5], 32'd5);

        // Taken BEQZ squashes the two writers behind it.
        prep("beqz_skip");
        put(0, ri(OP_BEQZ, 0, 0, 2));
        put(1, ri(OP_ADDI, 0, 6, 1));
        put(2, ri(OP_ADDI, 0, 7, 1));
        put(3, ri(OP_ADDI, 0, 8, 77));
        put(4, hlt());
        exp_wb(8, 77);
        run_prog(30, 9);
        check("r6_untouched", dut.Reg[6], 32'd6);
        check("r7_untouched", dut.Reg[7], 32'd7);
        check("r8", dut.Reg[8], 32'd77);

        // Asynchronous reset in mid-program, then a clean rerun from PC 0.
        prep("reset_pulse");
        load_fwd_prog();
        exp_wb(1, 10); exp_wb(2, 20);
        @(negedge clk1);
        rst_n = 1'b1;
        repeat (6) @(posedge clk1);
        #1;
        rst_n = 1'b0;
        #1;
        check("pc_after_reset", dut.PC, 32'd0);
        check("halted_after_reset", {31'd0, halted}, 32'd0);
        check("pipe_empty", {28'd0, dut.ifid_valid, dut.idex_valid, dut.exmem_valid, dut.memwb_valid}, 32'd0);
        check("r3_not_written", dut.Reg[3], 32'd3);
        check("partial_run_drained", exp_reg.size(), 32'd0);
        exp_wb(1, 10); exp_wb(2, 20); exp_wb(3, 10);
        run_prog(30, 8);
        check("r3_rerun", dut.Reg[3], 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
